etapa_busqueda: RTL and testbench

Instruction-fetch stage with IF/ID pipeline register for the MIPS datapath.
- Holds the PC and runs a request/ready handshake to instruction memory.
- Registers the fetched word and PC+4 for decode, and drives `codigo_operacion` directly into unidad_control.
- Applies hazard stalls and redirects from BEQ (resolved in EX) and J (decoded in ID).

---
 rtl/etapa_busqueda.sv | 140 ++++++++++++++
 tb/tb_etapa_busqueda.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/etapa_busqueda.sv
// MIPS instruction-fetch stage: PC, request/ready fetch handshake, skid buffer and IF/ID register.
// Redirects come from BEQ resolved in EX (highest priority) and J decoded in ID.
module etapa_busqueda #(
   parameter int unsigned         ANCHO_PC   = 32,
   parameter logic [ANCHO_PC-1:0] PC_INICIAL = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                detener,
   input  logic                branch_tomado,
   input  logic [ANCHO_PC-1:0] destino_branch,
   input  logic                salto,
   output logic                imem_solicitud,
   output logic [ANCHO_PC-1:0] imem_dir,
   input  logic                imem_listo,
   input  logic [ANCHO_PC-1:0] imem_dato,
   output logic [ANCHO_PC-1:0] instruccion_id,
   output logic [ANCHO_PC-1:0] pc_mas4_id,
   output logic                valido_id,
   output logic [5:0]          codigo_operacion,
   output logic [ANCHO_PC-1:0] pc_actual
);

   typedef enum logic [1:0] {StPedir, StRetenido, StDescartar} estado_e;

   estado_e             estado_q, estado_d;
   logic [ANCHO_PC-1:0] pc_q, pc_d;
   logic [ANCHO_PC-1:0] instr_q, instr_d;
   logic [ANCHO_PC-1:0] pm4_q, pm4_d;
   logic                valido_q, valido_d;
   logic [ANCHO_PC-1:0] skid_instr_q, skid_instr_d;
   logic [ANCHO_PC-1:0] skid_pm4_q, skid_pm4_d;
   logic [ANCHO_PC-1:0] dir_pend_q, dir_pend_d;

   logic [ANCHO_PC-1:0] pc_mas4;
   logic [ANCHO_PC-1:0] destino_j;
   logic [ANCHO_PC-1:0] destino;
   logic                salto_ok;
   logic                redirige;

   always_comb begin
      pc_mas4   = pc_q + ANCHO_PC'(4);
      destino_j = {pm4_q[ANCHO_PC-1 -: 4], instr_q[25:0], 2'b00};
      // A J sitting in a stalled or empty IF/ID slot must not redirect.
      salto_ok  = salto & valido_q & ~detener;
      redirige  = branch_tomado | salto_ok;
      destino   = branch_tomado ? destino_branch : destino_j;

      estado_d     = estado_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      pm4_d        = pm4_q;
      valido_d     = valido_q;
      skid_instr_d = skid_instr_q;
      skid_pm4_d   = skid_pm4_q;
      dir_pend_d   = dir_pend_q;

      unique case (estado_q)
         StPedir: begin
            if (redirige) begin
               pc_d     = destino;
               instr_d  = '0;
               valido_d = 1'b0;
               if (!imem_listo) begin
                  // Request in flight: keep its address until memory answers.
                  dir_pend_d = pc_q;
                  estado_d   = StDescartar;
               end
            end else if (imem_listo) begin
               pc_d = pc_mas4;
               if (detener) begin
                  skid_instr_d = imem_dato;
                  skid_pm4_d   = pc_mas4;
                  estado_d     = StRetenido;
               end else begin
                  instr_d  = imem_dato;
                  pm4_d    = pc_mas4;
                  valido_d = 1'b1;
               end
            end else if (!detener) begin
               instr_d  = '0;
               valido_d = 1'b0;
            end
         end
         StRetenido: begin
            if (redirige) begin
               pc_d     = destino;
               instr_d  = '0;
               valido_d = 1'b0;
               estado_d = StPedir;
            end else if (!detener) begin
               instr_d  = skid_instr_q;
               pm4_d    = skid_pm4_q;
               valido_d = 1'b1;
               estado_d = StPedir;
            end
         end
         StDescartar: begin
            if (branch_tomado) begin
               pc_d = destino_branch;
            end
            if (imem_listo) begin
               estado_d = StPedir;
            end
         end
         default: estado_d = StPedir;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q     <= StPedir;
         pc_q         <= PC_INICIAL;
         instr_q      <= '0;
         pm4_q        <= '0;
         valido_q     <= 1'b0;
         skid_instr_q <= '0;
         skid_pm4_q   <= '0;
         dir_pend_q   <= '0;
      end else begin
         estado_q     <= estado_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         pm4_q        <= pm4_d;
         valido_q     <= valido_d;
         skid_instr_q <= skid_instr_d;
         skid_pm4_q   <= skid_pm4_d;
         dir_pend_q   <= dir_pend_d;
      end
   end

   assign imem_solicitud   = ~reset & (estado_q != StRetenido);
   assign imem_dir         = (estado_q == StDescartar) ? dir_pend_q : pc_q;
   assign instruccion_id   = instr_q;
   assign pc_mas4_id       = pm4_q;
   assign valido_id        = valido_q;
   assign codigo_operacion = instr_q[ANCHO_PC-1 -: 6];
   assign pc_actual        = pc_q;

endmodule

// File: tb/tb_etapa_busqueda.sv
// Bench for etapa_busqueda: directed literal scenarios, then randomized traffic
// compared every cycle against a transaction-level fetch model.
module tb_etapa_busqueda;

   logic        clk = 1'b0;
   logic        reset, detener, branch_tomado, salto, imem_listo;
   logic [31:0] destino_branch;
   logic        imem_solicitud, valido_id;
   logic [31:0] imem_dir, imem_dato, instruccion_id, pc_mas4_id, pc_actual;
   logic [5:0]  codigo_operacion;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   etapa_busqueda dut (
      .clk              (clk),
      .reset            (reset),
      .detener          (detener),
      .branch_tomado    (branch_tomado),
      .destino_branch   (destino_branch),
      .salto            (salto),
      .imem_solicitud   (imem_solicitud),
      .imem_dir         (imem_dir),
      .imem_listo       (imem_listo),
      .imem_dato        (imem_dato),
      .instruccion_id   (instruccion_id),
      .pc_mas4_id       (pc_mas4_id),
      .valido_id        (valido_id),
      .codigo_operacion (codigo_operacion),
      .pc_actual        (pc_actual)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h8C08_0004;
         32'h0000_0004: mem_word = 32'h0000_0020;
         32'h0000_0008: mem_word = 32'hAC08_0008;
         32'h0040_0004: mem_word = 32'h0800_0010;
         default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
      endcase
   endfunction

   assign imem_dato = mem_word(imem_dir);

   // Model: fetch PC, IF/ID slot, a held word awaiting stall release, and an abandoned request.
   typedef struct {
      logic [31:0] ins;
      logic [31:0] pm4;
   } slot_t;

   logic [31:0] m_pc, m_ins, m_pm4;
   logic        m_val;
   slot_t       held[$];
   logic [31:0] abandoned[$];
   logic        modelo_ok = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic comparar();
      logic exp_sol;
      exp_sol = !reset && (held.size() == 0);
      chk("m_solicitud", imem_solicitud, exp_sol);
      if (exp_sol) chk("m_imem_dir", imem_dir, (abandoned.size() != 0) ? abandoned[0] : m_pc);
      chk("m_pc", pc_actual, m_pc);
      chk("m_instr", instruccion_id, m_ins);
      chk("m_valido", valido_id, m_val);
      chk("m_opcode", codigo_operacion, m_ins >> 26);
      if (m_val) chk("m_pc_mas4", pc_mas4_id, m_pm4);
   endtask

   task automatic actualizar();
      logic        jump, redir;
      logic [31:0] tgt;
      slot_t       s;
      if (reset) begin
         m_pc = 32'h0; m_ins = 32'h0; m_pm4 = 32'h0; m_val = 1'b0;
         held.delete(); abandoned.delete();
         return;
      end
      jump  = salto && m_val && !detener;
      redir = branch_tomado || jump;
      tgt   = branch_tomado ? destino_branch : ((m_pm4 & 32'hF000_0000) | ((m_ins & 32'h03FF_FFFF) << 2));
      if (abandoned.size() != 0) begin
         if (imem_listo) abandoned.delete();
         if (branch_tomado) m_pc = destino_branch;
      end else if (held.size() != 0) begin
         if (redir) begin
            m_pc = tgt; m_ins = 32'h0; m_val = 1'b0; held.delete();
         end else if (!detener) begin
            s = held.pop_front();
            m_ins = s.ins; m_pm4 = s.pm4; m_val = 1'b1;
         end
      end else if (redir) begin
         if (!imem_listo) abandoned.push_back(m_pc);
         m_pc = tgt; m_ins = 32'h0; m_val = 1'b0;
      end else if (imem_listo) begin
         s.ins = mem_word(m_pc);
         s.pm4 = m_pc + 32'd4;
         m_pc  = m_pc + 32'd4;
         if (detener) held.push_back(s);
         else begin
            m_ins = s.ins; m_pm4 = s.pm4; m_val = 1'b1;
         end
      end else if (!detener) begin
         m_ins = 32'h0; m_val = 1'b0;
      end
   endtask

   task automatic ciclo(input logic r, input logic d, input logic b, input logic [31:0] dst,
                        input logic s, input logic l);
      @(negedge clk);
      reset = r; detener = d; branch_tomado = b; destino_branch = dst; salto = s; imem_listo = l;
      #1;
      if (modelo_ok) comparar();
      @(posedge clk);
      actualizar();
      if (r) modelo_ok = 1'b1;
   endtask

   initial begin
      logic [31:0] dst;
      reset = 1'b1; detener = 1'b0; branch_tomado = 1'b0; salto = 1'b0;
      imem_listo = 1'b0; destino_branch = 32'h0;

      // Zero-wait stream
      ciclo(1, 0, 0, 0, 0, 1); #1;
      chk("rst_pc", pc_actual, 32'h0);
      chk("rst_valido", valido_id, 0);
      chk("rst_instr", instruccion_id, 32'h0);
      chk("rst_solicitud", imem_solicitud, 0);
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("zw_op0", codigo_operacion, 6'h23); chk("zw_pm4_0", pc_mas4_id, 32'h4);
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("zw_op1", codigo_operacion, 6'h00); chk("zw_pm4_1", pc_mas4_id, 32'h8);
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("zw_op2", codigo_operacion, 6'h2B); chk("zw_pm4_2", pc_mas4_id, 32'hC);

      // Wait states
      ciclo(1, 0, 0, 0, 0, 1);
      ciclo(0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         ciclo(0, 0, 0, 0, 0, 0); #1;
         chk("ws_dir", imem_dir, 32'h4);
         chk("ws_valido", valido_id, 0);
      end
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("ws_instr", instruccion_id, 32'h0000_0020); chk("ws_valido_on", valido_id, 1);

      // Stall with ready memory
      ciclo(0, 1, 0, 0, 0, 1); #1;
      chk("st_hold0", instruccion_id, 32'h0000_0020); chk("st_pc0", pc_actual, 32'hC);
      ciclo(0, 1, 0, 0, 0, 1); #1;
      chk("st_hold1", instruccion_id, 32'h0000_0020); chk("st_pc1", pc_actual, 32'hC);
      chk("st_no_req", imem_solicitud, 0);
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("st_release", instruccion_id, 32'hAC08_0008); chk("st_pm4", pc_mas4_id, 32'hC);
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("st_next", instruccion_id, mem_word(32'hC)); chk("st_next_pm4", pc_mas4_id, 32'h10);

      // J
      ciclo(0, 0, 1, 32'h0040_0004, 0, 1); #1;
      chk("j_setup_pc", pc_actual, 32'h0040_0004); chk("j_setup_val", valido_id, 0);
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("j_instr", instruccion_id, 32'h0800_0010); chk("j_pm4", pc_mas4_id, 32'h0040_0008);
      ciclo(0, 0, 0, 0, 1, 1); #1;
      chk("j_target", pc_actual, 32'h0000_0040); chk("j_bubble", valido_id, 0);

      // BEQ while memory is pending
      ciclo(0, 0, 1, 32'h100, 0, 0); #1;
      chk("beq_dir0", imem_dir, 32'h40); chk("beq_pc", pc_actual, 32'h100);
      chk("beq_req", imem_solicitud, 1);
      ciclo(0, 0, 0, 0, 0, 0); #1;
      chk("beq_dir1", imem_dir, 32'h40);
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("beq_newdir", imem_dir, 32'h100); chk("beq_discard", valido_id, 0);
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("beq_instr", instruccion_id, mem_word(32'h100)); chk("beq_pm4", pc_mas4_id, 32'h104);

      // Reset while holding a stalled word
      ciclo(0, 1, 0, 0, 0, 1); #1;
      chk("rs_held", imem_solicitud, 0);
      ciclo(1, 1, 0, 0, 0, 1); #1;
      chk("rs_pc", pc_actual, 32'h0); chk("rs_val", valido_id, 0); chk("rs_instr", instruccion_id, 32'h0);

      // PC+4 wraps
      ciclo(0, 0, 1, 32'hFFFF_FFFC, 0, 1); #1;
      chk("wr_pc", pc_actual, 32'hFFFF_FFFC);
      ciclo(0, 0, 0, 0, 0, 1); #1;
      chk("wr_pm4", pc_mas4_id, 32'h0); chk("wr_pc_next", pc_actual, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         dst = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         ciclo($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               dst, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      end
      ciclo(0, 0, 0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
